// File: rtl/ha_array_row_accumulator.sv
// ----------------------------------------------------------------------------
// ha_array_row_accumulator
//
// Reduces the ROWS row pairs (t = sum row, b = carry row) produced by the
// combinational ha-array partial-product generator into a single OUT_W-bit
// product. A single shared adder is time-multiplexed across the rows, one row
// per clock. Both sides use a valid/ready handshake.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   row vectors valid
//   in_ready_o   block can accept a transaction (high only in IDLE)
//   ha_t_i       packed t vectors, row k at [k*T_W +: T_W]
//   ha_b_i       packed b vectors, row k at [k*B_W +: B_W]
//   flush_i      synchronous abort, returns to IDLE and drops the transaction
//   out_valid_o  product valid (high only in DONE)
//   out_ready_i  consumer accepts the product
//   product_o    accumulated product, modulo 2^OUT_W
//   overflow_o   sticky flag: some addition carried out of bit OUT_W-1
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a transaction, in_ready high
// ACC   | adding one row per cycle, row index in cnt_q
// DONE  | result presented, held until out_ready
// ----------------------------------------------------------------------------
module ha_array_row_accumulator #(
    parameter int ROWS      = 4,
    parameter int T_W       = 9,
    parameter int B_W       = 7,
    parameter int B_OFF     = 2,
    parameter int ROW_SHIFT = 2,
    parameter int OUT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ROWS*T_W-1:0] ha_t_i,
    input  logic [ROWS*B_W-1:0] ha_b_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OUT_W-1:0]    product_o,
    output logic                overflow_o
);

    localparam int              CNT_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ROWS*T_W-1:0]  t_q;
    logic [ROWS*B_W-1:0]  b_q;
    logic [OUT_W-1:0]     acc_q;
    logic                 ovf_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [OUT_W:0]       row_ext;
    logic [OUT_W:0]       contrib_ext;
    logic [OUT_W:0]       sum;
    logic [OUT_W-1:0]     acc_d;
    logic                 ovf_d;

    // Row mux and shared adder. Each row is aligned with a constant shift
    // inside the loop, so no barrel shifter is built for the row weight.
    always_comb begin
        row_ext     = '0;
        contrib_ext = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                row_ext     = (OUT_W+1)'(t_q[k*T_W +: T_W])
                            + ((OUT_W+1)'(b_q[k*B_W +: B_W]) << B_OFF);
                contrib_ext = row_ext << (k * ROW_SHIFT);
            end
        end
        // Contributions beyond OUT_W bits wrap; the adder's extra bit is
        // only the carry out of the accumulator.
        sum   = {1'b0, acc_q} + {1'b0, contrib_ext[OUT_W-1:0]};
        acc_d = sum[OUT_W-1:0];
        ovf_d = ovf_q | sum[OUT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            t_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            // Abort wins over any handshake in the same cycle.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        t_q        <= ha_t_i;
                        b_q        <= ha_b_i;
                        acc_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    if (cnt_q == LAST_ROW) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // in_ready stays low through the exit cycle, so the
                    // earliest next accept is one cycle after the handshake.
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign product_o   = acc_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ha_array_row_accumulator.sv
module tb_ha_array_row_accumulator;

    localparam int ROWS = 4;
    localparam int T_W  = 9;
    localparam int B_W  = 7;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [ROWS*T_W-1:0] ha_t = '0;
    logic [ROWS*B_W-1:0] ha_b = '0;
    logic                flush = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [15:0]         product;
    logic                overflow;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];   // {overflow, product}

    ha_array_row_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ha_t_i      (ha_t),
        .ha_b_i      (ha_b),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference row-sum: exact integer sum, then wrap and flag.
    function automatic logic [16:0] model(input logic [ROWS*T_W-1:0] t,
                                          input logic [ROWS*B_W-1:0] b);
        int unsigned s = 0;
        int unsigned r;
        for (int k = 0; k < ROWS; k++) begin
            r = 32'(t[k*T_W +: T_W]) + (32'(b[k*B_W +: B_W]) << 2);
            s += r << (2 * k);
        end
        return {(s >= 32'd65536), s[15:0]};
    endfunction

    // Half-adder row pairs: row k combines pp(2k) and pp(2k+1)<<1.
    task automatic gen(input logic [7:0] x, input logic [7:0] y,
                       output logic [ROWS*T_W-1:0] t, output logic [ROWS*B_W-1:0] b);
        logic [7:0] pp0, pp1;
        logic [8:0] a, c, cy;
        t = '0;
        b = '0;
        for (int k = 0; k < ROWS; k++) begin
            pp0 = x & {8{y[2*k]}};
            pp1 = x & {8{y[2*k+1]}};
            a   = {1'b0, pp0};
            c   = {pp1, 1'b0};
            cy  = a & c;
            t[k*T_W +: T_W] = a ^ c;
            b[k*B_W +: B_W] = cy[7:1];
        end
    endtask

    task automatic accept(input logic [ROWS*T_W-1:0] t, input logic [ROWS*B_W-1:0] b,
                          input bit push);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_wait", 32'(w < 20), 32'd1);
        ha_t     = t;
        ha_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ha_t     = 36'({$urandom(), $urandom()});
        ha_b     = 28'($urandom());
        if (push) exp_q.push_back(model(t, b));
    endtask

    task automatic wait_valid();
        int lat = 0;
        while (!out_valid && lat < 20) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 4);
    endtask

    task automatic collect(input int hold);
        logic [16:0] held;
        logic [16:0] e;
        wait_valid();
        held = {overflow, product};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_stable", 32'({overflow, product}), 32'(held));
        end
        out_ready = 1'b1;
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("product", 32'(product), 32'(e[15:0]));
            chk("overflow", 32'(overflow), 32'(e[16]));
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_exit", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [ROWS*T_W-1:0] t;
        logic [ROWS*B_W-1:0] b;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: row0 t=1, consumer always ready
        out_ready = 1'b1;
        accept(36'h1, 28'h0, 1'b1);
        collect(0);
        chk("t1_product", 32'(model(36'h1, 28'h0)), 32'd1);

        // 2: row3 only, largest contribution without overflow
        t = '0; b = '0;
        t[3*T_W +: T_W] = 9'h1FF;
        b[3*B_W +: B_W] = 7'h7F;
        accept(t, b, 1'b1);
        collect(0);

        // 3: all rows maxed, wraps
        accept({ROWS{9'h1FF}}, {ROWS{7'h7F}}, 1'b1);
        collect(0);

        // 4: generator vectors, consumer stalls 5 cycles
        gen(8'd200, 8'd3, t, b);
        accept(t, b, 1'b1);
        wait_valid();
        chk("t4_xy", 32'(product), 32'd600);
        exp_q.push_front(exp_q.pop_front());
        begin
            // wait_valid already consumed the latency; collect re-checks it
            // from zero cycles, so hold directly here instead.
            logic [16:0] held;
            logic [16:0] e;
            held = {overflow, product};
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                chk("t4_hold_valid", 32'(out_valid), 32'd1);
                chk("t4_hold_stable", 32'({overflow, product}), 32'(held));
            end
            out_ready = 1'b1;
            e = exp_q.pop_front();
            chk("t4_product", 32'(product), 32'(e[15:0]));
            chk("t4_overflow", 32'(overflow), 32'(e[16]));
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("t4_valid_drop", 32'(out_valid), 32'd0);
        end

        // 5: flush in the second ACC cycle
        accept({ROWS{9'h0AB}}, {ROWS{7'h15}}, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_product", 32'(product), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("flush_no_valid", 32'(out_valid), 32'd0);
        end
        accept({ROWS{9'h123}}, {ROWS{7'h4D}}, 1'b1);
        collect(1);

        // 6a: async reset while DONE
        accept({ROWS{9'h1FF}}, {ROWS{7'h7F}}, 1'b0);
        wait_valid();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_product", 32'(product), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 6b: back-to-back random transactions
        for (int n = 0; n < 12; n++) begin
            t = 36'({$urandom(), $urandom()});
            b = 28'($urandom());
            accept(t, b, 1'b1);
            collect(n % 3);
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
